// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of JK flip-flops: masked HOLD/RESET/SET/TOGGLE/COUNT
// over valid/ready with a shadow copy of Q. Optional count-wrap pulse: JK_BANK_CTRL_WRAP_EN.
module jk_bank_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned REP_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [REP_W-1:0] cmd_repeat,
    output logic [WIDTH-1:0] J_OUT,
    output logic [WIDTH-1:0] K_OUT,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             wrap
);

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD   = 3'd0;
    localparam logic [OP_W-1:0] OP_RESET  = 3'd1;
    localparam logic [OP_W-1:0] OP_SET    = 3'd2;
    localparam logic [OP_W-1:0] OP_TOGGLE = 3'd3;
    localparam logic [OP_W-1:0] OP_COUNT  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] mask;
    } cmd_t;

    state_e           state_q;
    state_e           state_d;
    cmd_t             cmd_q;
    logic [REP_W-1:0] rem_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] t_c;
    logic [WIDTH-1:0] j_c;
    logic [WIDTH-1:0] k_c;
    logic             err_q;
    logic             op_legal_c;
    logic             accept_c;

    assign op_legal_c = (cmd_op <= OP_COUNT);
    assign accept_c   = cmd_valid & cmd_ready;

    // Ripple toggle enables for the masked up-counter; unmasked bits pass the carry through.
    always_comb begin : count_toggle
        logic carry;
        carry = 1'b1;
        t_c   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            t_c[i] = cmd_q.mask[i] & carry;
            carry  = carry & (q_q[i] | ~cmd_q.mask[i]);
        end
    end

    // J/K decode of the latched command
    always_comb begin
        j_c = '0;
        k_c = '0;
        case (cmd_q.op)
            OP_RESET: begin
                k_c = cmd_q.mask;
            end
            OP_SET: begin
                j_c = cmd_q.mask;
            end
            OP_TOGGLE: begin
                j_c = cmd_q.mask;
                k_c = cmd_q.mask;
            end
            OP_COUNT: begin
                j_c = t_c;
                k_c = t_c;
            end
            default: begin
                j_c = '0;
                k_c = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        J_OUT     = '0;
        K_OUT     = '0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                busy  = 1'b1;
                J_OUT = j_c;
                K_OUT = k_c;
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Command latch, repeat counter, shadow bank and sticky error.
    // Illegal ops are stored as HOLD so the decode never sees them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd_q <= '0;
            rem_q <= '0;
            q_q   <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept_c) begin
                cmd_q.op   <= op_legal_c ? cmd_op : OP_HOLD;
                cmd_q.mask <= cmd_mask;
                rem_q      <= cmd_repeat;
                if (!op_legal_c) begin
                    err_q <= 1'b1;
                end
            end
            if (state_q == ST_APPLY) begin
                q_q <= (J_OUT & ~q_q) | (~K_OUT & q_q);
                if (rem_q != '0) begin
                    rem_q <= rem_q - REP_W'(1);
                end
            end
        end
    end

`ifdef JK_BANK_CTRL_WRAP_EN
    logic wrap_q;
    logic wrap_hit_c;

    assign wrap_hit_c = (state_q == ST_APPLY) && (cmd_q.op == OP_COUNT) &&
                        (|cmd_q.mask) && (&(q_q | ~cmd_q.mask));

    // Pulse after the edge on which the masked field rolls over to zero
    always_ff @(posedge CLK) begin
        if (RST) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_hit_c;
        end
    end

    assign wrap = wrap_q;
`else
    assign wrap = 1'b0;
`endif

    assign Q   = q_q;
    assign err = err_q;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Self-checking bench for jk_bank_ctrl: directed vector table, multi-cycle corner
// sequences and random commands against a field-level reference model.
module tb_jk_bank_ctrl;

    localparam int unsigned W = 4;
    localparam int unsigned R = 4;

`ifdef JK_BANK_CTRL_WRAP_EN
    localparam int WRAP_ON = 1;
`else
    localparam int WRAP_ON = 0;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = '0;
    logic [W-1:0] cmd_mask = '0;
    logic [R-1:0] cmd_repeat = '0;
    logic [W-1:0] J_OUT;
    logic [W-1:0] K_OUT;
    logic [W-1:0] Q;
    logic         busy;
    logic         done;
    logic         err;
    logic         wrap;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] q_m = '0;
    logic         err_m = 1'b0;
    logic         wrap_m = 1'b0;
    int           wrap_seen = 0;

    jk_bank_ctrl #(.WIDTH(W), .REP_W(R)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_mask   (cmd_mask),
        .cmd_repeat (cmd_repeat),
        .J_OUT      (J_OUT),
        .K_OUT      (K_OUT),
        .Q          (Q),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .wrap       (wrap)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Masked field treated as an unsigned number, incremented modulo 2^popcount(mask)
    function automatic logic [W-1:0] masked_inc(input logic [W-1:0] q, input logic [W-1:0] mask);
        int v = 0;
        int n = 0;
        logic [W-1:0] r = q;
        for (int i = 0; i < int'(W); i++) begin
            if (mask[i]) begin
                if (q[i]) v = v | (1 << n);
                n++;
            end
        end
        v = v + 1;
        n = 0;
        for (int i = 0; i < int'(W); i++) begin
            if (mask[i]) begin
                r[i] = ((v >> n) & 1) != 0;
                n++;
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] next_q(input logic [2:0] op, input logic [W-1:0] q,
                                            input logic [W-1:0] mask);
        case (op)
            3'd1:    return q & ~mask;
            3'd2:    return q | mask;
            3'd3:    return q ^ mask;
            3'd4:    return masked_inc(q, mask);
            default: return q;
        endcase
    endfunction

    function automatic logic [W-1:0] exp_j(input logic [2:0] op, input logic [W-1:0] q,
                                           input logic [W-1:0] mask);
        case (op)
            3'd2, 3'd3: return mask;
            3'd4:       return q ^ masked_inc(q, mask);
            default:    return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] exp_k(input logic [2:0] op, input logic [W-1:0] q,
                                           input logic [W-1:0] mask);
        case (op)
            3'd1, 3'd3: return mask;
            3'd4:       return q ^ masked_inc(q, mask);
            default:    return '0;
        endcase
    endfunction

    task automatic do_reset();
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        q_m = '0;
        err_m = 1'b0;
        wrap_m = 1'b0;
        chk("rst_q", 32'(Q), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_jk", {16'(J_OUT), 16'(K_OUT)}, 32'h0);
        chk("rst_flags", {29'(0), done, err, wrap}, 32'h0);
    endtask

    // Issue one command from IDLE (called at a negedge) and check it cycle by cycle to IDLE.
    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] mask, input logic [R-1:0] rep);
        chk("idle_ready", 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_mask = mask;
        cmd_repeat = rep;
        @(negedge CLK);
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom_range(0, 7));
        cmd_mask = W'($urandom);
        if (op > 3'd4) err_m = 1'b1;
        wrap_m = 1'b0;
        for (int c = 0; c <= int'(rep); c++) begin
            chk("apply_j", 32'(J_OUT), 32'(exp_j(op, q_m, mask)));
            chk("apply_k", 32'(K_OUT), 32'(exp_k(op, q_m, mask)));
            chk("apply_q", 32'(Q), 32'(q_m));
            chk("apply_ctl", {28'(0), busy, cmd_ready, done, err}, {28'(0), 1'b1, 1'b0, 1'b0, err_m});
            chk("apply_wrap", 32'(wrap), 32'(wrap_m));
            if (wrap) wrap_seen++;
            wrap_m = (WRAP_ON != 0) && (op == 3'd4) && (mask != '0) && ((q_m & mask) == mask);
            q_m = next_q(op, q_m, mask);
            @(negedge CLK);
        end
        chk("done_ctl", {28'(0), busy, cmd_ready, done, err}, {28'(0), 1'b1, 1'b0, 1'b1, err_m});
        chk("done_jk", {16'(J_OUT), 16'(K_OUT)}, 32'h0);
        chk("done_q", 32'(Q), 32'(q_m));
        chk("done_wrap", 32'(wrap), 32'(wrap_m));
        if (wrap) wrap_seen++;
        wrap_m = 1'b0;
        @(negedge CLK);
        chk("post_ctl", {28'(0), busy, cmd_ready, done, wrap}, {28'(0), 1'b0, 1'b1, 1'b0, 1'b0});
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] mask;
        logic [R-1:0] rep;
        logic [W-1:0] exp_q;
        logic         exp_err;
        int           exp_wraps;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int dones;
        logic [W-1:0] q_start;

        vecs.push_back('{3'd2, 4'b0101, 4'd0,  4'b0101, 1'b0, 0});
        vecs.push_back('{3'd3, 4'b1111, 4'd2,  4'b1010, 1'b0, 0});
        vecs.push_back('{3'd2, 4'b1111, 4'd0,  4'b1111, 1'b0, 0});
        vecs.push_back('{3'd1, 4'b0011, 4'd0,  4'b1100, 1'b0, 0});
        vecs.push_back('{3'd4, 4'b0000, 4'd3,  4'b1100, 1'b0, 0});
        vecs.push_back('{3'd1, 4'b1111, 4'd1,  4'b0000, 1'b0, 0});
        vecs.push_back('{3'd4, 4'b1111, 4'd15, 4'b0000, 1'b0, WRAP_ON});
        vecs.push_back('{3'd4, 4'b1010, 4'd4,  4'b0010, 1'b0, WRAP_ON});
        vecs.push_back('{3'd6, 4'b1111, 4'd1,  4'b0010, 1'b1, 0});
        vecs.push_back('{3'd2, 4'b0101, 4'd0,  4'b0111, 1'b1, 0});

        @(negedge CLK);
        do_reset();

        foreach (vecs[i]) begin
            wrap_seen = 0;
            run_cmd(vecs[i].op, vecs[i].mask, vecs[i].rep);
            chk($sformatf("vec%0d_q", i), 32'(Q), 32'(vecs[i].exp_q));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_wraps", i), 32'(wrap_seen), 32'(vecs[i].exp_wraps));
        end

        // Reset during the third APPLY cycle of a long COUNT aborts it without a done pulse
        do_reset();
        cmd_valid = 1'b1;
        cmd_op = 3'd4;
        cmd_mask = 4'b1111;
        cmd_repeat = 4'd15;
        @(negedge CLK);
        cmd_valid = 1'b0;
        dones = 0;
        for (int c = 0; c < 2; c++) begin
            if (done) dones++;
            @(negedge CLK);
        end
        chk("abort_q_mid", 32'(Q), 32'h2);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_q", 32'(Q), 32'h0);
        chk("abort_ctl", {28'(0), cmd_ready, busy, err, wrap}, {28'(0), 1'b1, 1'b0, 1'b0, 1'b0});
        for (int c = 0; c < 20; c++) begin
            if (done) dones++;
            @(negedge CLK);
        end
        chk("abort_no_done", 32'(dones), 32'h0);
        q_m = '0;
        err_m = 1'b0;
        wrap_m = 1'b0;

        // cmd_valid held high: one accept per repeat+3 cycles, none while busy
        q_start = Q;
        dones = 0;
        cmd_valid = 1'b1;
        cmd_op = 3'd3;
        cmd_mask = 4'b0001;
        cmd_repeat = 4'd0;
        for (int c = 0; c < 9; c++) begin
            @(negedge CLK);
            if (done) dones++;
        end
        cmd_valid = 1'b0;
        chk("b2b_dones", 32'(dones), 32'd3);
        chk("b2b_q", 32'(Q), 32'(q_start ^ 4'b0001));
        chk("b2b_ready", 32'(cmd_ready), 32'h1);
        q_m = Q == (q_start ^ 4'b0001) ? Q : (q_start ^ 4'b0001);

        // Random commands against the model
        for (int n = 0; n < 60; n++) begin
            logic [2:0]   op;
            logic [W-1:0] mask;
            logic [R-1:0] rep;
            op   = 3'($urandom_range(0, 7));
            mask = W'($urandom);
            rep  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            wrap_seen = 0;
            run_cmd(op, mask, rep);
            chk("rnd_q", 32'(Q), 32'(q_m));
            chk("rnd_err", 32'(err), 32'(err_m));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge CLK);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
- Command sequencer for a bank of WIDTH JK flip-flops sharing one clock.
- Accepts masked bit-operation commands over a valid/ready handshake and drives per-bit J/K lines for a programmable number of cycles.
- Keeps a shadow copy of the bank state so that a synchronous up-count mode can be built from the same JK cells.
- Sits between control logic and the JK register bank; external JK cells on CLK fed J_OUT/K_OUT track Q exactly.

Parameters:
- WIDTH, 4, number of JK flip-flops in the bank.
- REP_W, 4, width of the repeat-count field.

Ports:
- CLK, input, 1, system clock; rising edge.
- RST, input, 1, synchronous, active-high reset.
- cmd_valid, input, 1, command present.
- cmd_ready, output, 1, controller can accept a command.
- cmd_op, input, 3, operation: 0 HOLD, 1 RESET, 2 SET, 3 TOGGLE, 4 COUNT, 5-7 illegal.
- cmd_mask, input, WIDTH, bits affected by the command.
- cmd_repeat, input, REP_W, number of apply cycles minus 1.
- J_OUT, output, WIDTH, J drive to the bank.
- K_OUT, output, WIDTH, K drive to the bank.
- Q, output, WIDTH, shadow bank state.
- busy, output, 1, high in APPLY and DONE.
- done, output, 1, one-cycle pulse when a command completes.
- err, output, 1, sticky illegal-op flag.
- wrap, output, 1, one-cycle count-wrap pulse (see Optional Feature).

Behaviour:
- Reset (CLK edge with RST=1):
  - state=IDLE; Q=0; err=0; done=0; wrap=0.
  - J_OUT=K_OUT=0; cmd_ready=1 after reset; busy=0.
  - RST has priority over every other event.
- Reset mid-operation: command aborted, no done pulse, latched command discarded.
- State IDLE:
  - cmd_ready=1; J_OUT=K_OUT=0.
  - Handshake: cmd_valid&cmd_ready at an edge latches op, mask and repeat into rem; next state APPLY.
- State APPLY:
  - cmd_ready=0; J_OUT/K_OUT driven combinationally from latched op, mask and current Q.
  - HOLD: J=0, K=0.
  - RESET: J=0, K=mask.
  - SET: J=mask, K=0.
  - TOGGLE: J=K=mask.
  - COUNT: T_i = mask_i AND (AND of Q_j for all masked j<i); lowest masked bit has T=1; J=K=T.
  - Illegal op (5-7): treated as HOLD; err set at the latch edge and held until RST.
- Shadow update on every APPLY edge, per bit: Q_i <= (J_i & ~Q_i) | (~K_i & Q_i). Unmasked bits never change.
- Cycle count: rem decrements each APPLY edge. At the edge where rem==0, state goes to DONE, so APPLY lasts exactly cmd_repeat+1 cycles.
- State DONE:
  - done=1 for exactly one cycle; J_OUT=K_OUT=0; cmd_ready=0; next state IDLE.
- A command presented during APPLY or DONE is not accepted; cmd_valid must be held until cmd_ready.
- Latency: accept edge, then first J/K drive in the following cycle, then done asserted cycle cmd_repeat+2 after accept.
- Back-to-back throughput: one command per cmd_repeat+3 cycles.
- Mask 0: runs the full duration with no Q change; COUNT with mask 0 drives J=K=0.
- Width rules: rem is REP_W bits and never underflows.

Optional Feature:
- Macro: JK_BANK_CTRL_WRAP_EN.
- Defined: in COUNT, wrap pulses high for one cycle following an APPLY edge where all masked Q bits were 1 (masked field rolls to 0). Mask 0 never wraps.
- Undefined: wrap is tied to 0 and no detection logic is built. All other behaviour is identical.

Test Plan:
- Reset, then SET mask 0101 repeat 0 -> J_OUT=0101, K_OUT=0000 for one cycle; Q=0101; done pulses 2 cycles after accept; cmd_ready returns to 1.
- From Q=0101, TOGGLE mask 1111 repeat 2 -> three toggles, Q=1010; busy high for 4 cycles.
- From Q=1111, RESET mask 0011 repeat 0 -> K_OUT=0011, J_OUT=0000 during APPLY; Q=1100.
- From Q=0000, COUNT mask 1111 repeat 15 -> Q steps 1,2,...,15,0; done pulses once. With JK_BANK_CTRL_WRAP_EN, wrap pulses once on the 15->0 step; without it, wrap stays 0.
- cmd_op=6, mask 1111 repeat 1 -> Q unchanged; err=1 and stays 1 across a following SET until RST.
- RST asserted on the 3rd APPLY cycle of COUNT repeat 15 -> next cycle Q=0000, cmd_ready=1, done never pulses.
